ld_to_affine571: RTL and testbench



---
 rtl/ld_to_affine571_if.sv | 18 +
 rtl/ld_to_affine571.sv | 239 +++++++++++++++++++++++
 tb/tb_ld_to_affine571.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ld_to_affine571_if.sv
// Request/result bundle of the LD-projective to affine converter for sect571r1.
interface ld_to_affine571_if;
  logic         start;
  logic [570:0] X1;
  logic [570:0] Y1;
  logic [570:0] Z1;
  logic [570:0] x_aff;
  logic [570:0] y_aff;
  logic         inf;
  logic         inv_ok;
  logic         busy;
  logic         done;

  modport master (output start, X1, Y1, Z1,
                  input  x_aff, y_aff, inf, inv_ok, busy, done);
  modport slave  (input  start, X1, Y1, Z1,
                  output x_aff, y_aff, inf, inv_ok, busy, done);
endinterface

// File: rtl/ld_to_affine571.sv
// sect571r1 LD (X:Y:Z) -> affine (X/Z, Y/Z^2) via Itoh-Tsujii inversion.
// Optional LD_INV_CHECK_EN adds a Z*Z^-1 == 1 self-check multiply.

// Combinational GF(2^571) squarer, f(x) = x^571 + x^10 + x^5 + x^2 + 1.
module squerer_571 (
  input  logic [570:0] a,
  output logic [570:0] c
);
  logic [1140:0] t;
  always_comb begin
    t = '0;
    for (int i = 0; i < 571; i++) t[2*i] = a[i];
    for (int i = 1140; i >= 571; i--) begin
      if (t[i]) begin
        t[i]     = 1'b0;
        t[i-571] = ~t[i-571];
        t[i-569] = ~t[i-569];
        t[i-566] = ~t[i-566];
        t[i-561] = ~t[i-561];
      end
    end
    c = t[570:0];
  end
endmodule

// GF(2^571) multiplier, 3-cycle latency from a/b to c.
module gf2m_mult571 (
  input  logic         clk,
  input  logic         rst,
  input  logic [570:0] a,
  input  logic [570:0] b,
  output logic [570:0] c
);
  logic [570:0] prod;
  logic [570:0] p1_reg, p2_reg;

  always_comb begin
    prod = '0;
    for (int i = 570; i >= 0; i--) begin
      prod = {prod[569:0], 1'b0} ^ (prod[570] ? 571'h425 : 571'h0);
      if (b[i]) prod = prod ^ a;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_reg <= '0;
      p2_reg <= '0;
      c      <= '0;
    end else begin
      p1_reg <= prod;
      p2_reg <= p1_reg;
      c      <= p2_reg;
    end
  end
endmodule

module ld_to_affine571 (
  input  logic              clk,
  input  logic              rst,
  ld_to_affine571_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, LOAD, SQR, MUL, FIN} state_t;
  typedef enum logic [2:0] {ST_DBL, ST_INC, ST_INV, ST_CHK, ST_XM, ST_ZI2, ST_YM} stage_t;

  // Bits of 570 below its MSB, consumed MSB first.
  localparam logic [8:0] K_BITS = 9'b000111010;

  state_t       state_reg;
  stage_t       stage_reg;
  logic [570:0] x_reg, y_reg, z_reg, c_reg, t_reg, xr_reg, op_a_reg, op_b_reg;
  logic [570:0] x_aff_reg, y_aff_reg;
  logic [9:0]   k_reg, sqr_cnt_reg;
  logic [1:0]   mult_cnt_reg;
  logic [3:0]   bit_idx_reg;
  logic         inf_reg, inv_ok_reg, busy_reg, done_reg;
`ifdef LD_INV_CHECK_EN
  logic         chk_reg;
`endif

  logic [570:0] sqr_out, mult_out;
  logic [9:0]   k_dbl, k_inc;
  logic         cur_bit, last_bit;

  squerer_571  u_sqr (.a(c_reg), .c(sqr_out));
  gf2m_mult571 u_mul (.clk(clk), .rst(rst), .a(op_a_reg), .b(op_b_reg), .c(mult_out));

  assign k_dbl    = {k_reg[8:0], 1'b0};
  assign k_inc    = k_reg + 10'd1;
  assign cur_bit  = K_BITS[4'd8 - bit_idx_reg];
  assign last_bit = (bit_idx_reg == 4'd8);

  assign bus.x_aff  = x_aff_reg;
  assign bus.y_aff  = y_aff_reg;
  assign bus.inf    = inf_reg;
  assign bus.inv_ok = inv_ok_reg;
  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      stage_reg    <= ST_DBL;
      x_reg        <= '0;
      y_reg        <= '0;
      z_reg        <= '0;
      c_reg        <= '0;
      t_reg        <= '0;
      xr_reg       <= '0;
      op_a_reg     <= '0;
      op_b_reg     <= '0;
      x_aff_reg    <= '0;
      y_aff_reg    <= '0;
      k_reg        <= '0;
      sqr_cnt_reg  <= '0;
      mult_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      inf_reg      <= 1'b0;
      inv_ok_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
`ifdef LD_INV_CHECK_EN
      chk_reg      <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        // FIN is the done cycle; it accepts a new request like IDLE.
        IDLE, FIN: begin
          state_reg <= IDLE;
          if (bus.start) begin
            if (bus.Z1 == '0) begin
              x_aff_reg  <= '0;
              y_aff_reg  <= '0;
              inf_reg    <= 1'b1;
              inv_ok_reg <= 1'b1;
              done_reg   <= 1'b1;
            end else begin
              x_reg     <= bus.X1;
              y_reg     <= bus.Y1;
              z_reg     <= bus.Z1;
              inf_reg   <= 1'b0;
              busy_reg  <= 1'b1;
              state_reg <= LOAD;
            end
          end
        end
        LOAD: begin
          c_reg       <= z_reg;
          t_reg       <= z_reg;
          k_reg       <= 10'd1;
          sqr_cnt_reg <= 10'd1;
          bit_idx_reg <= '0;
          stage_reg   <= ST_DBL;
          state_reg   <= SQR;
        end
        SQR: begin
          c_reg       <= sqr_out;
          sqr_cnt_reg <= sqr_cnt_reg - 10'd1;
          if (sqr_cnt_reg == 10'd1) begin
            state_reg    <= MUL;
            mult_cnt_reg <= '0;
            op_a_reg     <= sqr_out;
            case (stage_reg)
              ST_DBL: op_b_reg <= t_reg;
              ST_INC: op_b_reg <= z_reg;
              ST_INV: begin
`ifdef LD_INV_CHECK_EN
                op_b_reg  <= z_reg;
                stage_reg <= ST_CHK;
`else
                op_b_reg  <= x_reg;
                stage_reg <= ST_XM;
`endif
              end
              default: begin
                op_b_reg  <= y_reg;
                stage_reg <= ST_YM;
              end
            endcase
          end
        end
        MUL: begin
          mult_cnt_reg <= mult_cnt_reg + 2'd1;
          if (mult_cnt_reg == 2'd3) begin
            case (stage_reg)
              ST_DBL, ST_INC: begin
                c_reg <= mult_out;
                k_reg <= (stage_reg == ST_DBL) ? k_dbl : k_inc;
                state_reg <= SQR;
                if (stage_reg == ST_DBL && cur_bit) begin
                  stage_reg   <= ST_INC;
                  sqr_cnt_reg <= 10'd1;
                end else if (last_bit) begin
                  stage_reg   <= ST_INV;
                  sqr_cnt_reg <= 10'd1;
                end else begin
                  // Next doubling: square beta_k k times, then multiply by beta_k.
                  bit_idx_reg <= bit_idx_reg + 4'd1;
                  t_reg       <= mult_out;
                  sqr_cnt_reg <= (stage_reg == ST_DBL) ? k_dbl : k_inc;
                  stage_reg   <= ST_DBL;
                end
              end
`ifdef LD_INV_CHECK_EN
              ST_CHK: begin
                chk_reg   <= (mult_out == 571'd1);
                op_a_reg  <= x_reg;
                op_b_reg  <= c_reg;
                stage_reg <= ST_XM;
              end
`endif
              ST_XM: begin
                xr_reg      <= mult_out;
                sqr_cnt_reg <= 10'd1;
                stage_reg   <= ST_ZI2;
                state_reg   <= SQR;
              end
              ST_YM: begin
                x_aff_reg <= xr_reg;
                y_aff_reg <= mult_out;
`ifdef LD_INV_CHECK_EN
                inv_ok_reg <= chk_reg;
`else
                inv_ok_reg <= 1'b1;
`endif
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
                state_reg <= FIN;
              end
              default: state_reg <= IDLE;
            endcase
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ld_to_affine571.sv
// Randomised self-checking bench for ld_to_affine571 against a Fermat-inversion field model.
module tb_ld_to_affine571;
`ifdef LD_INV_CHECK_EN
  localparam int LAT = 637;
`else
  localparam int LAT = 633;
`endif
  localparam int BUDGET = 800;

  localparam logic [570:0] GX = 571'h0303001D_34B85629_6C16C0D4_0D3CD775_0A93D1D2_955FA80A_A5F40FC8_DB7B2ABD_BDE53950_F4C0D293_CDD711A3_5B67FB14_99AE6003_8614F139_4ABFA3B4_C850D927_E1E7769C_8EEC2D19;
  localparam logic [570:0] GY = 571'h037BF273_42DA639B_6DCCFFFE_B73D69D7_8C6C27A6_009CBBCA_1980F853_3921E8A6_84423E43_BAB08A57_6291AF8F_461BB2A8_B3531D2F_0485C19B_16E2F151_6E23DD3C_1A4827AF_1B8AC15B;
  localparam logic [570:0] GZ = 571'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321_1357_9BDF_2468_ACE0_ABCD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail  = 0;

  ld_to_affine571_if bus();
  ld_to_affine571 dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Schoolbook product followed by long division by the field polynomial.
  function automatic logic [570:0] m_mul(input logic [570:0] a, input logic [570:0] b);
    logic [1141:0] p, red;
    p = '0;
    for (int i = 0; i < 571; i++) if (b[i]) p ^= ({571'b0, a} << i);
    red = '0;
    red[571] = 1'b1; red[10] = 1'b1; red[5] = 1'b1; red[2] = 1'b1; red[0] = 1'b1;
    for (int i = 1141; i >= 571; i--) if (p[i]) p ^= (red << (i - 571));
    return p[570:0];
  endfunction

  // z^(2^571 - 2) = product of z^(2^i), i = 1..570.
  function automatic logic [570:0] m_inv(input logic [570:0] z);
    logic [570:0] r, s;
    r = 571'd1;
    s = z;
    for (int i = 1; i <= 570; i++) begin
      s = m_mul(s, s);
      r = m_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [570:0] rand571();
    logic [575:0] tmp;
    for (int w = 0; w < 18; w++) tmp[w*32 +: 32] = $urandom();
    return tmp[570:0];
  endfunction

  task automatic start_job(input logic [570:0] x, input logic [570:0] y, input logic [570:0] z);
    bus.X1 = x; bus.Y1 = y; bus.Z1 = z; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.X1 = rand571(); bus.Y1 = rand571(); bus.Z1 = rand571();
  endtask

  task automatic wait_done(input int budget, output int lat, output logic busy1);
    lat = 0;
    busy1 = 1'b0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (n == 1) busy1 = bus.busy;
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus.x_aff, bus.y_aff} !== '0) begin n_fail++; $display("FAIL reset_xy: got x=%0h y=%0h, want 0", bus.x_aff, bus.y_aff); end
    n_tests++;
    if ({bus.inf, bus.inv_ok, bus.busy, bus.done} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got inf/inv_ok/busy/done=%b, want 0000", {bus.inf, bus.inv_ok, bus.busy, bus.done});
    end
  endtask

  task automatic test_identity();
    int lat; logic b1;
    start_job(571'd5, 571'd7, 571'd1);
    wait_done(BUDGET, lat, b1);
    n_tests++;
    if (lat != LAT) begin n_fail++; $display("FAIL ident_latency: got %0d, want %0d", lat, LAT); end
    n_tests++;
    if (b1 !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL ident_busy: got cycle1=%b at_done=%b, want 1/0", b1, bus.busy); end
    n_tests++;
    if (bus.x_aff !== 571'd5 || bus.y_aff !== 571'd7) begin n_fail++; $display("FAIL ident_xy: got x=%0h y=%0h, want 5/7", bus.x_aff, bus.y_aff); end
    n_tests++;
    if (bus.inf !== 1'b0 || bus.inv_ok !== 1'b1) begin n_fail++; $display("FAIL ident_flags: got inf=%b inv_ok=%b, want 0/1", bus.inf, bus.inv_ok); end
    @(negedge clk);
    n_tests++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL ident_done_pulse: got done=%b one cycle later, want 0", bus.done); end
    $display("[TB] identity job: lat=%0d x=%0h y=%0h", lat, bus.x_aff, bus.y_aff);
  endtask

  task automatic test_small();
    int lat; logic b1;
    start_job(571'd2, 571'd4, 571'd2);
    wait_done(BUDGET, lat, b1);
    n_tests++;
    if (lat != LAT || bus.x_aff !== 571'd1 || bus.y_aff !== 571'd1) begin
      n_fail++; $display("FAIL small: got lat=%0d x=%0h y=%0h, want %0d/1/1", lat, bus.x_aff, bus.y_aff, LAT);
    end
    $display("[TB] small job: lat=%0d x=%0h y=%0h", lat, bus.x_aff, bus.y_aff);
  endtask

  task automatic test_generator();
    int lat; logic b1;
    start_job(m_mul(GX, GZ), m_mul(GY, m_mul(GZ, GZ)), GZ);
    wait_done(BUDGET, lat, b1);
    n_tests++;
    if (lat != LAT || bus.x_aff !== GX) begin n_fail++; $display("FAIL gen_x: got lat=%0d x=%0h, want %0d/%0h", lat, bus.x_aff, LAT, GX); end
    n_tests++;
    if (bus.y_aff !== GY) begin n_fail++; $display("FAIL gen_y: got %0h, want %0h", bus.y_aff, GY); end
    $display("[TB] generator job: lat=%0d", lat);
  endtask

  task automatic test_random();
    int lat; logic b1;
    logic [570:0] x, y, z, zi;
    for (int it = 0; it < 3; it++) begin
      x = rand571(); y = rand571(); z = rand571() | 571'd1;
      zi = m_inv(z);
      start_job(x, y, z);
      wait_done(BUDGET, lat, b1);
      n_tests++;
      if (lat != LAT || bus.x_aff !== m_mul(x, zi) || bus.y_aff !== m_mul(y, m_mul(zi, zi)) || bus.inv_ok !== 1'b1) begin
        n_fail++; $display("FAIL random_%0d: got lat=%0d x=%0h y=%0h inv_ok=%b", it, lat, bus.x_aff, bus.y_aff, bus.inv_ok);
      end
      $display("[TB] random job %0d: lat=%0d", it, lat);
    end
  endtask

  task automatic test_infinity();
    int lat; logic b1;
    start_job(571'd1, 571'd1, 571'd0);
    wait_done(8, lat, b1);
    n_tests++;
    if (lat != 1 || b1 !== 1'b0) begin n_fail++; $display("FAIL inf_latency: got lat=%0d busy=%b, want 1/0", lat, b1); end
    n_tests++;
    if (bus.x_aff !== '0 || bus.y_aff !== '0 || bus.inf !== 1'b1 || bus.inv_ok !== 1'b1) begin
      n_fail++; $display("FAIL inf_result: got x=%0h y=%0h inf=%b inv_ok=%b, want 0/0/1/1", bus.x_aff, bus.y_aff, bus.inf, bus.inv_ok);
    end
    $display("[TB] infinity job: lat=%0d inf=%b", lat, bus.inf);
  endtask

  task automatic test_ignore_start();
    int lat = 0;
    logic [570:0] x, y, z, zi, prev_x;
    x = rand571(); y = rand571(); z = rand571() | 571'd2;
    zi = m_inv(z);
    prev_x = bus.x_aff;
    start_job(x, y, z);
    for (int n = 1; n <= BUDGET; n++) begin
      @(negedge clk);
      if (n == 99) begin bus.start = 1'b1; bus.X1 = 571'd3; bus.Y1 = 571'd3; bus.Z1 = 571'd1; end
      if (n == 100) begin
        bus.start = 1'b0;
        n_tests++;
        if (bus.x_aff !== prev_x) begin n_fail++; $display("FAIL ignore_hold: got x=%0h mid-job, want %0h", bus.x_aff, prev_x); end
      end
      if (bus.done === 1'b1) begin lat = n; break; end
    end
    n_tests++;
    if (lat != LAT || bus.x_aff !== m_mul(x, zi) || bus.y_aff !== m_mul(y, m_mul(zi, zi))) begin
      n_fail++; $display("FAIL ignore_start: got lat=%0d x=%0h y=%0h, want lat %0d", lat, bus.x_aff, bus.y_aff, LAT);
    end
    $display("[TB] ignore-start job: lat=%0d", lat);
  endtask

  task automatic test_reset_mid();
    int lat; int done_seen = 0; logic b1;
    start_job(rand571(), rand571(), rand571() | 571'd4);
    for (int n = 1; n < 300; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({bus.x_aff, bus.y_aff} !== '0 || {bus.inf, bus.inv_ok, bus.busy, bus.done} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_mid_outputs: got x=%0h y=%0h flags=%b, want all 0", bus.x_aff, bus.y_aff, {bus.inf, bus.inv_ok, bus.busy, bus.done});
    end
    repeat (700) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    n_tests++;
    if (done_seen != 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d done pulses, want 0", done_seen); end
    start_job(571'd3, 571'd9, 571'd1);
    wait_done(BUDGET, lat, b1);
    n_tests++;
    if (lat != LAT || bus.x_aff !== 571'd3 || bus.y_aff !== 571'd9) begin
      n_fail++; $display("FAIL rst_mid_newjob: got lat=%0d x=%0h y=%0h, want %0d/3/9", lat, bus.x_aff, bus.y_aff, LAT);
    end
    $display("[TB] reset-mid then job: lat=%0d x=%0h y=%0h", lat, bus.x_aff, bus.y_aff);
  endtask

  task automatic test_back_to_back();
    int lat; logic b1;
    logic [570:0] x1, y1, z1, x2, y2, z2, zi;
    x1 = rand571(); y1 = rand571(); z1 = rand571() | 571'd8;
    x2 = rand571(); y2 = rand571(); z2 = rand571() | 571'd16;
    start_job(x1, y1, z1);
    wait_done(BUDGET, lat, b1);
    zi = m_inv(z1);
    n_tests++;
    if (lat != LAT || bus.x_aff !== m_mul(x1, zi) || bus.y_aff !== m_mul(y1, m_mul(zi, zi))) begin
      n_fail++; $display("FAIL b2b_first: got lat=%0d x=%0h y=%0h", lat, bus.x_aff, bus.y_aff);
    end
    start_job(x2, y2, z2);
    wait_done(BUDGET, lat, b1);
    zi = m_inv(z2);
    n_tests++;
    if (lat != LAT || b1 !== 1'b1 || bus.x_aff !== m_mul(x2, zi) || bus.y_aff !== m_mul(y2, m_mul(zi, zi))) begin
      n_fail++; $display("FAIL b2b_second: got lat=%0d busy1=%b x=%0h y=%0h, want lat %0d", lat, b1, bus.x_aff, bus.y_aff, LAT);
    end
    $display("[TB] back-to-back second job: lat=%0d", lat);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.X1 = '0; bus.Y1 = '0; bus.Z1 = '0;
    test_reset();
    test_identity();
    test_small();
    test_generator();
    test_random();
    test_infinity();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
